// File: rtl/full_adder.sv
// 1-bit full adder cell with a zero-latency combinational result,
// a registered copy of that result, and a saturating carry-event counter.
module full_adder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic             sum,
    output logic             carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] carry_cnt
);

    logic             sum_d;
    logic             carry_d;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_sat;

    // Primary result: no dependence on clk, rst_n or in_valid.
    assign sum   = a ^ b ^ c_in;
    assign carry = (a & b) | (a & c_in) | (b & c_in);

    assign cnt_sat = &carry_cnt;

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = in_valid;
        cnt_d   = carry_cnt;
        if (in_valid) begin
            sum_d   = sum;
            carry_d = carry;
            if (carry && !cnt_sat) begin
                cnt_d = carry_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= 1'b0;
            carry_q   <= 1'b0;
            valid_q   <= 1'b0;
            carry_cnt <= '0;
        end else begin
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            valid_q   <= valid_d;
            carry_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: arithmetic reference model,
// directed corner cases and randomized traffic.
module tb_full_adder;

    logic        clk;
    logic        rst_n;
    logic        a, b, c_in, in_valid;
    logic        sum, carry, sum_q, carry_q, valid_q;
    logic [15:0] carry_cnt;

    logic        s2_sum, s2_carry, s2_sum_q, s2_carry_q, s2_valid_q;
    logic [1:0]  s2_cnt;

    logic        clk_z, rst_z;
    logic        u_sum, u_carry, u_sum_q, u_carry_q, u_valid_q;
    logic [15:0] u_cnt;

    int n_cmp = 0;
    int n_err = 0;

    int exp_s, exp_c, exp_v, exp_cnt16, exp_cnt2;

    full_adder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in),
        .in_valid(in_valid), .sum(sum), .carry(carry),
        .sum_q(sum_q), .carry_q(carry_q), .valid_q(valid_q),
        .carry_cnt(carry_cnt)
    );

    full_adder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in),
        .in_valid(in_valid), .sum(s2_sum), .carry(s2_carry),
        .sum_q(s2_sum_q), .carry_q(s2_carry_q), .valid_q(s2_valid_q),
        .carry_cnt(s2_cnt)
    );

    full_adder #(.CNT_W(16)) dut_undrv (
        .clk(clk_z), .rst_n(rst_z), .a(a), .b(b), .c_in(c_in),
        .in_valid(in_valid), .sum(u_sum), .carry(u_carry),
        .sum_q(u_sum_q), .carry_q(u_carry_q), .valid_q(u_valid_q),
        .carry_cnt(u_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_comb(input string tag);
        int tot;
        tot = int'(a) + int'(b) + int'(c_in);
        chk({tag, ".sum"}, 32'(sum), 32'(tot % 2));
        chk({tag, ".carry"}, 32'(carry), 32'(tot / 2));
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".sum_q"}, 32'(sum_q), 32'(exp_s));
        chk({tag, ".carry_q"}, 32'(carry_q), 32'(exp_c));
        chk({tag, ".valid_q"}, 32'(valid_q), 32'(exp_v));
        chk({tag, ".cnt16"}, 32'(carry_cnt), 32'(exp_cnt16));
        chk({tag, ".cnt2"}, 32'(s2_cnt), 32'(exp_cnt2));
    endtask

    task automatic model_reset();
        exp_s = 0; exp_c = 0; exp_v = 0;
        exp_cnt16 = 0; exp_cnt2 = 0;
    endtask

    // Drive at negedge, let one rising edge pass, check at next negedge.
    task automatic cycle(input logic [2:0] abc, input logic v,
                         input string tag);
        int tot;
        {a, b, c_in} = abc;
        in_valid = v;
        tot = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            model_reset();
        end else if (v) begin
            exp_s = tot % 2;
            exp_c = tot / 2;
            exp_v = 1;
            if (exp_c == 1) begin
                if (exp_cnt16 < 65535) exp_cnt16++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end else begin
            exp_v = 0;
        end
        @(negedge clk);
        chk_regs(tag);
    endtask

    int tt [8] = '{0, 1, 1, 2, 1, 2, 2, 3};

    initial begin
        logic [2:0] pat;
        rst_n = 1'b0;
        {a, b, c_in} = 3'b000;
        in_valid = 1'b0;
        model_reset();
        #1;
        chk_regs("reset");

        for (int i = 0; i < 8; i++) begin
            pat = 3'(i);
            {a, b, c_in} = pat;
            #1;
            chk($sformatf("tt%0d", i), 32'({carry, sum}), 32'(tt[i]));
        end

        {a, b, c_in} = 3'b111;
        #1;
        chk("undrv.sum", 32'(u_sum), 32'd1);
        chk("undrv.carry", 32'(u_carry), 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        cycle(3'b110, 1'b1, "reg_cap");
        chk("reg_cap.sum_q_lit", 32'(sum_q), 32'd0);
        chk("reg_cap.carry_q_lit", 32'(carry_q), 32'd1);
        cycle(3'b001, 1'b0, "reg_hold");
        chk("reg_hold.sum_q_lit", 32'(sum_q), 32'd0);
        chk("reg_hold.carry_q_lit", 32'(carry_q), 32'd1);
        chk("reg_hold.valid_lit", 32'(valid_q), 32'd0);

        rst_n = 1'b0;
        #1;
        model_reset();
        chk_regs("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pat = (i % 2 == 0) ? 3'b111 : 3'b000;
            cycle(pat, 1'b1, $sformatf("cnt%0d", i));
        end
        chk("cnt_final", 32'(carry_cnt), 32'd3);

        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(3'b011, 1'b1, $sformatf("sat%0d", i));
        end
        chk("sat_final", 32'(s2_cnt), 32'd3);

        for (int i = 0; i < 300; i++) begin
            pat = 3'($urandom_range(0, 7));
            {a, b, c_in} = pat;
            #1;
            chk_comb("rnd_comb");
            cycle(pat, 1'($urandom_range(0, 3) != 0), "rnd");
        end

        cycle(3'b111, 1'b1, "pre_arst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_regs("arst");
        chk_comb("arst_comb");
        cycle(3'b111, 1'b1, "rst_override");
        rst_n = 1'b1;
        cycle(3'b101, 1'b1, "first_cap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
